inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch stage placed directly downstream of `pc_incrementor`. It reads the current PC word address, issues reads to a synchronous instruction memory and buffers the returned instructions in a small FIFO for decode. It is the sole driver of the incrementor's `en`, `wen` and `pc_in`. It also applies branch redirects from execute.

## Interface
- `INST_ADDR_WIDTH`, 6: word-address width; must match `pc_incrementor`.
- `INST_WIDTH`, 32: instruction width.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, ≥2.

- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse; leaves IDLE.
- `halt_req`  in  1: stop issuing new fetches.
- `pc`  in  INST_ADDR_WIDTH+2: byte PC from `pc_incrementor.pc_out`; word = `pc[W+1:2]`.
- `pc_en`  out  1: to incrementor `en`.
- `pc_wen`  out  1: to incrementor `wen`.
- `pc_in`  out  INST_ADDR_WIDTH: next word address.
- `imem_rd_en`  out  1: memory read strobe.
- `imem_addr`  out  INST_ADDR_WIDTH: memory word address.
- `imem_rdata`  in  INST_WIDTH: read data, valid the cycle after `imem_rd_en`.
- `redirect_valid`  in  1: branch or jump taken.
- `redirect_addr`  in  INST_ADDR_WIDTH: target word address.
- `out_valid`  out  1: instruction available.
- `out_ready`  in  1: decode accepts.
- `out_inst`  out  INST_WIDTH: instruction.
- `out_pc`  out  INST_ADDR_WIDTH+2: byte address `{word,2'b00}`.

## Operation
- FSM states:
  - IDLE: reset state. `start` goes to RUN. `redirect_valid` goes to RUN.
  - RUN: fetching. `halt_req` goes to HALTED.
  - HALTED: `redirect_valid` goes to RUN. `start` is ignored.
- Issue condition: state RUN, `!redirect_valid`, and `count + inflight < FIFO_DEPTH`. The condition uses registered values only; there is no path from `out_ready`.
- On issue:
  - `imem_rd_en=1`, `imem_addr=pc[W+1:2]`.
  - `pc_en=1`, `pc_wen=1`, `pc_in=pc[W+1:2]+1`. The addition wraps mod 2^W, so `2^W-1` goes to 0.
  - Set `inflight=1`.
- The incrementor's +1 path is never used: `pc_wen` is 1 whenever `pc_en` is 1. `pc[1:0]` stays 0 and is ignored.
- Response: when `inflight=1`, capture `{imem_rdata, issued address}` into the FIFO at the end of the cycle, then clear `inflight`.
- Redirect, in any state:
  - `pc_en=1`, `pc_wen=1`, `pc_in=redirect_addr`.
  - No issue that cycle; the FIFO is flushed to `count=0`.
  - The response arriving that cycle is dropped and `inflight` is cleared.
  - Redirect has priority over `halt_req`, `start`, pop and push.
- Output: `out_valid = (count != 0) && !redirect_valid`. A pop occurs on `out_valid && out_ready`. `out_inst` and `out_pc` hold the FIFO head and are stable while stalled.
- Halt: in-flight response and FIFO contents still drain to decode. No new issue.
- When nothing is issued, `pc_en=0` and the PC holds.
- Simultaneous push and pop: `count` is unchanged.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `count=0`, `inflight=0`, FIFO pointers 0. All outputs 0: `pc_en`, `pc_wen`, `pc_in`, `imem_rd_en`, `imem_addr`, `out_valid`, `out_inst`, `out_pc`.
- Reset mid-operation discards all in-flight and buffered instructions.
- Issue in cycle t → `pc` shows the next word in t+1 → FIFO write at the end of t+1 → `out_valid` in t+2. Issue-to-decode latency is 2 cycles.
- Steady state with `out_ready=1`: one instruction per cycle.
- Redirect in cycle t → `pc = {redirect_addr,2'b00}` in t+1 → first issue in t+1 → `out_valid` in t+3.
- Full condition `count+inflight == FIFO_DEPTH`: issue stalls and the PC holds.

## Structure
- Package `arya_fetch_pkg` holds:
  - FSM state typedef (IDLE, RUN, HALTED).
  - FIFO entry struct `{inst, word_addr}`.
  - Default width constants.
- Sub-module `fetch_fifo`: synchronous FIFO with flush, push, pop and count.
- The top-level module holds the FSM, issue/credit logic and PC control.

## Test plan
- Reset, `start`, `out_ready=1`, memory `mem[i]=i+0x100` → `out_pc` = 0x00, 0x04, 0x08… with `out_inst` 0x100, 0x101…; first `out_valid` 2 cycles after `start`; one instruction per cycle.
- `out_ready=0` after `start` → exactly 4 instructions buffered, `pc_en` low; `out_inst` stays 0x100 until `out_ready` rises.
- `redirect_valid`, `redirect_addr=0x20` while the FIFO holds 3 entries → `out_valid` low that cycle; next delivered `out_pc`=0x80 with `out_inst` 0x120; no stale instruction delivered.
- PC at word 63 (W=6) → next fetch is word 0; `out_pc` sequence 0xFC, 0x00.
- `halt_req` in RUN → buffered entries drain and no further `imem_rd_en`. Then `redirect_addr=5` → fetch resumes at `out_pc` 0x14.
- `reset_n` low mid-stream with the FIFO full → all outputs 0 immediately; after release the state is IDLE and no fetch occurs until `start`.

Source files
------------

// File: rtl/arya_fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package arya_fetch_pkg;

   localparam int unsigned INST_ADDR_WIDTH_DEF = 6;
   localparam int unsigned INST_WIDTH_DEF      = 32;
   localparam int unsigned FIFO_DEPTH_DEF      = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INST_WIDTH_DEF-1:0]      inst;
      logic [INST_ADDR_WIDTH_DEF-1:0] word_addr;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: PC control, instruction memory, redirect and decode handoff.
interface inst_fetch_unit_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned INST_W = 32
);
   logic [ADDR_W+1:0] pc;
   logic              pc_en;
   logic              pc_wen;
   logic [ADDR_W-1:0] pc_in;
   logic              imem_rd_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [INST_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [ADDR_W+1:0] out_pc;

   modport master (
      input  pc, imem_rdata, redirect_valid, redirect_addr, out_ready,
      output pc_en, pc_wen, pc_in, imem_rd_en, imem_addr, out_valid, out_inst, out_pc
   );

   modport slave (
      output pc, imem_rdata, redirect_valid, redirect_addr, out_ready,
      input  pc_en, pc_wen, pc_in, imem_rd_en, imem_addr, out_valid, out_inst, out_pc
   );
endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with flush, head-of-queue view and occupancy count.
module fetch_fifo
   import arya_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((32'(count) < DEPTH) || do_pop);
   assign head    = mem[rd_ptr];

   // Storage is cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: drives the PC incrementor, issues imem reads under a FIFO credit and handles redirects.
module inst_fetch_unit
   import arya_fetch_pkg::*;
#(
   parameter int unsigned INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
   parameter int unsigned INST_WIDTH      = INST_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               halt_req,
   inst_fetch_unit_if.master  bus
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e               state;
   logic                       inflight;
   logic [INST_ADDR_WIDTH-1:0] issued_addr;
   logic [CNT_W-1:0]           count;
   logic                       issue_c;
   logic [INST_ADDR_WIDTH-1:0] pc_word_c;
   logic [INST_WIDTH-1:0]      rdata_c;
   logic                       pop_c;
   fetch_entry_t               push_entry;
   fetch_entry_t               head;
   logic                       unused_pc_lsb;

   assign pc_word_c     = bus.pc[INST_ADDR_WIDTH+1:2];
   assign unused_pc_lsb = ^bus.pc[1:0];
   assign rdata_c       = bus.imem_rdata;

   // Credit check counts the outstanding read so a full FIFO never overflows.
   assign issue_c = (state == ST_RUN) && !bus.redirect_valid &&
                    ((32'(count) + 32'(inflight)) < FIFO_DEPTH);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         inflight    <= 1'b0;
         issued_addr <= '0;
      end else begin
         inflight <= issue_c;
         if (issue_c) issued_addr <= pc_word_c;
         unique case (state)
            ST_IDLE:   if (start || bus.redirect_valid) state <= ST_RUN;
            ST_RUN:    if (!bus.redirect_valid && halt_req) state <= ST_HALTED;
            ST_HALTED: if (bus.redirect_valid) state <= ST_RUN;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // PC is always loaded explicitly; redirect outranks a normal issue.
   always_comb begin
      bus.pc_en      = 1'b0;
      bus.pc_wen     = 1'b0;
      bus.pc_in      = '0;
      bus.imem_rd_en = 1'b0;
      bus.imem_addr  = '0;
      if (bus.redirect_valid) begin
         bus.pc_en  = 1'b1;
         bus.pc_wen = 1'b1;
         bus.pc_in  = bus.redirect_addr;
      end else if (issue_c) begin
         bus.pc_en      = 1'b1;
         bus.pc_wen     = 1'b1;
         bus.pc_in      = pc_word_c + INST_ADDR_WIDTH'(1);
         bus.imem_rd_en = 1'b1;
         bus.imem_addr  = pc_word_c;
      end
   end

   assign push_entry = '{inst: rdata_c, word_addr: issued_addr};
   assign pop_c      = bus.out_valid && bus.out_ready;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (bus.redirect_valid),
      .push      (inflight && !bus.redirect_valid),
      .push_data (push_entry),
      .pop       (pop_c),
      .head      (head),
      .count     (count)
   );

   assign bus.out_valid = (count != '0) && !bus.redirect_valid;
   assign bus.out_inst  = head.inst;
   assign bus.out_pc    = {head.word_addr, 2'b00};
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a PC incrementor, imem model and stream scoreboard.
module tb_inst_fetch_unit;
   localparam int unsigned W = 6;

   logic clk      = 1'b0;
   logic reset_n  = 1'b0;
   logic start    = 1'b0;
   logic halt_req = 1'b0;
   int   errors   = 0;
   int   checks   = 0;

   inst_fetch_unit_if #(.ADDR_W(W), .INST_W(32)) bus ();

   inst_fetch_unit #(.INST_ADDR_WIDTH(W), .INST_WIDTH(32), .FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .halt_req (halt_req),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Environment: pc_incrementor and a synchronous memory holding mem[i] = i + 0x100.
   logic [W+1:0] pc_q;
   logic [31:0]  rdata_q;
   assign bus.pc         = pc_q;
   assign bus.imem_rdata = rdata_q;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) pc_q <= '0;
      else if (bus.pc_en) pc_q <= bus.pc_wen ? {bus.pc_in, 2'b00} : pc_q + 8'd4;
   end

   always @(posedge clk) begin
      if (bus.imem_rd_en) rdata_q <= 32'h100 + 32'(bus.imem_addr);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: delivered stream is consecutive words from the last redirect (or reset), mod 2^W.
   logic [W-1:0] exp_word  = '0;
   int           rd_count  = 0;
   int           dlv_count = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_word = '0;
      end else begin
         if (bus.imem_rd_en) begin
            rd_count++;
            check("issue_ctl", {bus.pc_en, bus.pc_wen, bus.imem_addr, bus.pc_in},
                  {1'b1, 1'b1, pc_q[W+1:2], W'(pc_q[W+1:2] + 1)});
         end
         if (bus.redirect_valid)
            check("redirect_ctl", {bus.out_valid, bus.imem_rd_en, bus.pc_en, bus.pc_wen, bus.pc_in},
                  {1'b0, 1'b0, 1'b1, 1'b1, bus.redirect_addr});
         else if (!bus.imem_rd_en)
            check("pc_hold", 64'(bus.pc_en), 64'd0);
         if (bus.out_valid && bus.out_ready) begin
            dlv_count++;
            check("deliver", {bus.out_pc, bus.out_inst}, {exp_word, 2'b00, 32'h100 + 32'(exp_word)});
            exp_word = exp_word + W'(1);
         end
         if (bus.redirect_valid) exp_word = bus.redirect_addr;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pc_ctl"}, {bus.pc_en, bus.pc_wen, bus.pc_in}, 64'd0);
      check({tag, "_imem"}, {bus.imem_rd_en, bus.imem_addr}, 64'd0);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_out_inst"}, 64'(bus.out_inst), 64'd0);
      check({tag, "_out_pc"}, 64'(bus.out_pc), 64'd0);
   endtask

   // Leaves the bench at the negedge of the first cycle with out_valid high.
   task automatic wait_valid(input string name, input int max_cyc, output int waited);
      waited = 0;
      @(negedge clk);
      while (!bus.out_valid && waited < max_cyc) begin
         next_cycle();
         @(negedge clk);
         waited++;
      end
      if (!bus.out_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: out_valid timeout after %0d cycles", name, waited);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      int snap_rd;
      int snap_dlv;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = '0;
      bus.out_ready      = 1'b0;

      // Reset values and idle behaviour
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      next_cycle();
      reset_n = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("idle_no_fetch", 64'(bus.imem_rd_en), 64'd0);

      // Start with decode always ready: 2-cycle issue latency, one instruction per cycle
      next_cycle();
      bus.out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check("start_cycle", {bus.out_valid, bus.imem_rd_en}, 64'd0);
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      check("first_issue", {bus.imem_rd_en, bus.imem_addr}, {1'b1, 6'd0});
      next_cycle();
      @(negedge clk);
      check("lat_t1", 64'(bus.out_valid), 64'd0);
      next_cycle();
      @(negedge clk);
      check("lat_t2", {bus.out_valid, bus.out_pc, bus.out_inst}, {1'b1, 8'h00, 32'h100});
      for (int k = 1; k <= 6; k++) begin
         next_cycle();
         @(negedge clk);
         check("stream", {bus.out_valid, bus.out_pc, bus.out_inst}, {1'b1, 8'(4 * k), 32'h100 + 32'(k)});
      end

      // Decode stalled: exactly four fetches fill the buffer, head holds
      next_cycle();
      reset_n = 1'b0;
      bus.out_ready = 1'b0;
      next_cycle();
      reset_n = 1'b1;
      next_cycle();
      snap_rd = rd_count;
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      repeat (8) next_cycle();
      @(negedge clk);
      check("full_issues", 64'(rd_count - snap_rd), 64'd4);
      check("full_stall", {bus.pc_en, bus.imem_rd_en, bus.out_valid, bus.out_inst}, {1'b0, 1'b0, 1'b1, 32'h100});
      next_cycle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("stall_release", {bus.out_valid, bus.out_inst}, {1'b1, 32'h100});

      // Redirect with three buffered entries
      next_cycle();
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 6'h20;
      @(negedge clk);
      check("redirect_hides_valid", 64'(bus.out_valid), 64'd0);
      next_cycle();
      bus.redirect_valid = 1'b0;
      bus.out_ready = 1'b1;
      wait_valid("redirect_resume", 8, waited);
      check("redirect_latency", 64'(waited), 64'd2);
      check("redirect_target", {bus.out_pc, bus.out_inst}, {8'h80, 32'h120});
      repeat (3) next_cycle();

      // Word address wraps from 63 to 0
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 6'd63;
      next_cycle();
      bus.redirect_valid = 1'b0;
      wait_valid("wrap_resume", 8, waited);
      check("wrap_first", {bus.out_pc, bus.out_inst}, {8'hFC, 32'h13F});
      next_cycle();
      @(negedge clk);
      check("wrap_second", {bus.out_valid, bus.out_pc, bus.out_inst}, {1'b1, 8'h00, 32'h100});

      // Halt drains the in-flight read and buffer, ignores start, then redirect resumes
      next_cycle();
      halt_req = 1'b1;
      next_cycle();
      halt_req = 1'b0;
      snap_rd = rd_count;
      snap_dlv = dlv_count;
      next_cycle();
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      repeat (5) next_cycle();
      @(negedge clk);
      check("halt_no_issue", 64'(rd_count - snap_rd), 64'd0);
      check("halt_drain", {bus.out_valid, 32'(dlv_count - snap_dlv)}, {1'b0, 32'd2});
      next_cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_addr = 6'd5;
      next_cycle();
      bus.redirect_valid = 1'b0;
      wait_valid("halt_resume", 8, waited);
      check("halt_resume_target", {bus.out_pc, bus.out_inst}, {8'h14, 32'h105});

      // Reset while the buffer is full: outputs clear at once, no fetch until start
      next_cycle();
      bus.out_ready = 1'b0;
      repeat (8) next_cycle();
      @(negedge clk);
      check("pre_reset_full", {bus.out_valid, bus.pc_en}, {1'b1, 1'b0});
      next_cycle();
      reset_n = 1'b0;
      #1;
      check_zero("reset_mid");
      next_cycle();
      next_cycle();
      reset_n = 1'b1;
      bus.out_ready = 1'b1;
      snap_rd = rd_count;
      repeat (5) next_cycle();
      @(negedge clk);
      check("post_reset_idle", {bus.out_valid, 32'(rd_count - snap_rd)}, 64'd0);
      next_cycle();
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      wait_valid("restart", 8, waited);
      check("restart_latency", 64'(waited), 64'd2);
      check("restart_first", {bus.out_pc, bus.out_inst}, {8'h00, 32'h100});
      repeat (3) next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
